// File: rtl/frame_mapper.sv
`default_nettype none
// ============================================================================
// Module      : frame_mapper
// Description : Sender-side framing stage. Builds a continuous 4-row x COLS
//               byte frame. Row 0 begins with a FAS overhead pattern. All
//               other slots carry upstream payload taken over a valid/ready
//               handshake, or a filler byte when upstream has nothing ready.
//               Outputs are registered, so each slot appears one cycle after
//               it is generated.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_mapper #(
    parameter int          COLS    = 1024,
    parameter int          FAS_LEN = 6,
    parameter logic [7:0]  FAS_A   = 8'hF6,
    parameter logic [7:0]  FAS_B   = 8'h28,
    parameter logic [7:0]  FILL    = 8'h55
) (
    input  logic        i_clk,
    input  logic        i_rst,              // asynchronous, active-low
    input  logic        i_frame_en,
    input  logic [7:0]  i_pyld_data,
    input  logic        i_pyld_valid,
    output logic        o_pyld_ready,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic [7:0]  o_pyld_data,
    output logic        o_pyld_data_valid,
    output logic        o_frame_data_fas,
    output logic [15:0] o_underrun_cnt
);

    localparam logic [0:0]  c_st_idle  = 1'b0;
    localparam logic [0:0]  c_st_run   = 1'b1;
    localparam logic [10:0] c_last_col = 11'(COLS - 1);
    localparam logic [10:0] c_fas_len  = 11'(FAS_LEN);
    localparam logic [10:0] c_fas_half = 11'(FAS_LEN / 2);
    localparam logic [15:0] c_und_max  = 16'hFFFF;

    logic [0:0]  r_state;
    logic [1:0]  r_row;
    logic [10:0] r_col;
    logic [1:0]  r_out_row;
    logic [10:0] r_out_col;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic        r_out_fas;
    logic [15:0] r_und_cnt;

    logic        w_fas_slot;
    logic        w_last_slot;
    logic        w_ready;

    // Classify the slot being generated this cycle and derive the handshake
    always_comb begin
        w_fas_slot  = (r_row == 2'd0) && (r_col < c_fas_len);
        w_last_slot = (r_row == 2'd3) && (r_col == c_last_col);
        w_ready     = (r_state == c_st_run) && !w_fas_slot;
    end

    // Slot sequencer, payload/filler/FAS selection and the output register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= c_st_idle;
            r_row       <= 2'd0;
            r_col       <= 11'd0;
            r_out_row   <= 2'd0;
            r_out_col   <= 11'd0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_fas   <= 1'b0;
            r_und_cnt   <= 16'd0;
        end else if (r_state == c_st_idle) begin
            // Row/col outputs keep their last values while idle
            r_row       <= 2'd0;
            r_col       <= 11'd0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_fas   <= 1'b0;
            if (i_frame_en) begin
                r_state <= c_st_run;
            end
        end else begin
            r_out_row   <= r_row;
            r_out_col   <= r_col;
            r_out_valid <= 1'b1;
            if (w_fas_slot) begin
                r_out_fas  <= 1'b1;
                r_out_data <= (r_col < c_fas_half) ? FAS_A : FAS_B;
            end else if (i_pyld_valid) begin
                r_out_fas  <= 1'b0;
                r_out_data <= i_pyld_data;
            end else begin
                r_out_fas  <= 1'b0;
                r_out_data <= FILL;
                if (r_und_cnt != c_und_max) begin
                    r_und_cnt <= r_und_cnt + 16'd1;
                end
            end
            // Row counter wraps 3 -> 0 naturally at the frame boundary
            if (r_col == c_last_col) begin
                r_col <= 11'd0;
                r_row <= r_row + 2'd1;
            end else begin
                r_col <= r_col + 11'd1;
            end
            // Stopping is only honoured on the last slot, so frames are never cut short
            if (w_last_slot && !i_frame_en) begin
                r_state <= c_st_idle;
            end
        end
    end

    assign o_pyld_ready      = w_ready;
    assign o_row_cnt         = r_out_row;
    assign o_col_cnt         = r_out_col;
    assign o_pyld_data       = r_out_data;
    assign o_pyld_data_valid = r_out_valid;
    assign o_frame_data_fas  = r_out_fas;
    assign o_underrun_cnt    = r_und_cnt;

endmodule
`default_nettype wire

// File: doc/frame_mapper.md
Name: frame_mapper

Overview:
- Sender-side framing stage directly upstream of the corruptor.
- Builds a continuous 4-row x COLS-column byte frame. Row 0 starts with a fixed FAS overhead pattern. Every other slot is filled with payload pulled from the upstream source through a valid/ready handshake, or with a filler byte on underrun.
- Drives the corruptor's row/column counters, data, valid and FAS inputs.

Parameters:
- COLS, 1024: columns per row; legal range 8..2047 (fits 11-bit column count).
- FAS_LEN, 6: overhead bytes at row 0, columns 0..FAS_LEN-1.
- FAS_A, 8'hF6: FAS byte for columns 0..FAS_LEN/2-1.
- FAS_B, 8'h28: FAS byte for columns FAS_LEN/2..FAS_LEN-1.
- FILL, 8'h55: filler byte inserted on payload underrun.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_frame_en  in  1  start/keep framing; stops only at a frame boundary.
- i_pyld_data  in  8  upstream payload byte.
- i_pyld_valid  in  1  upstream byte available.
- o_pyld_ready  out  1  mapper takes i_pyld_data this cycle if i_pyld_valid.
- o_row_cnt  out  2  row of the output byte.
- o_col_cnt  out  11  column of the output byte.
- o_pyld_data  out  8  output frame byte (FAS, payload or filler).
- o_pyld_data_valid  out  1  output byte valid.
- o_frame_data_fas  out  1  output byte is a FAS overhead byte.
- o_underrun_cnt  out  16  saturating count of filler insertions.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - All outputs 0; o_underrun_cnt=0.
  - State=IDLE; internal slot counters row=0, col=0.
  - Reset asserted mid-frame aborts immediately; no partial-frame completion.
- Internal slot counters (row, col) name the slot generated this cycle.
  - col increments each RUN cycle and wraps COLS-1 -> 0 with row+1.
  - row wraps 3 -> 0 (frame boundary).
- State machine:
  - IDLE: counters held at 0; o_pyld_ready=0; o_pyld_data_valid=0. If i_frame_en=1, go to RUN; the first RUN cycle generates slot (0,0).
  - RUN: one slot per cycle, every cycle (no backpressure from downstream).
    - At the last slot (row 3, col COLS-1): if i_frame_en=0, go to IDLE after generating that slot; otherwise continue to (0,0).
    - i_frame_en deasserted mid-frame has no effect until the boundary; reasserting before the boundary cancels the stop.
- Slot classification:
  - FAS slot: row=0 and col<FAS_LEN.
  - Payload slot: every other slot.
- Handshake:
  - o_pyld_ready is combinational: 1 only when state=RUN and the current slot is a payload slot.
  - A transfer occurs when o_pyld_ready and i_pyld_valid are both 1.
  - i_pyld_valid with ready=0 consumes nothing; upstream holds its data.
- Output register, one-cycle latency. Slot generated in cycle N appears at the outputs in cycle N+1:
  - o_row_cnt and o_col_cnt carry that slot's row and col.
  - o_pyld_data_valid=1 for every RUN slot.
  - FAS slot: o_pyld_data = FAS_A or FAS_B by column; o_frame_data_fas=1.
  - Payload slot with transfer: o_pyld_data = i_pyld_data; fas=0.
  - Payload slot without valid (underrun): o_pyld_data = FILL; fas=0; o_underrun_cnt+1, saturating at 16'hFFFF.
  - The cycle after IDLE is entered: valid=0, fas=0, data=0. Row/col outputs hold their last values.
- Width rules: o_col_cnt is zero-extended from the internal counter; COLS-1 always fits in 11 bits.
- A frame is never shortened: each started frame emits exactly 4*COLS valid bytes.

Test Plan:
- Reset then i_frame_en=1, i_pyld_valid always 1, payload incrementing from 8'h00:
  - First valid output at (0,0)=F6, fas=1.
  - (0,0)..(0,2)=F6 and (0,3)..(0,5)=28, all with fas=1.
  - (0,6)=8'h00, fas=0; ready=0 for the first 6 slots of row 0.
- Full frame with COLS=1024: exactly 4096 valid bytes per frame; col wraps 1023->0 with row+1; row wraps 3->0; the second frame's (0,0) is F6.
- i_pyld_valid=0 for 3 payload slots: three 8'h55 bytes at those positions; o_underrun_cnt=3; no upstream byte is lost or duplicated.
- i_frame_en dropped at (1,10): framing continues to (3,COLS-1), then valid=0. Re-asserting i_frame_en restarts at (0,0) with FAS.
- i_rst=0 asserted mid-row 2: all outputs are 0 asynchronously, before the next clock edge. After release with i_frame_en=1, the frame restarts at (0,0).
- Force 65536+ underruns (i_pyld_valid=0): o_underrun_cnt holds at 16'hFFFF.
